// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle MSB-first slice comparator with cascade inputs and start/done handshake.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             isEqual,
    input  logic             isGreater,
    input  logic             isLess,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             A_greater,
    output logic             A_less
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    typedef enum logic {IDLE, COMPARE} state_t;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, w_msb;
    logic [IW-1:0]    r_idx;
    logic             r_ce, r_cg, r_cl, r_done, r_eq, r_gt, r_lt;
    logic [SLICE-1:0] w_sa, w_sb;
    logic             w_fin;
    logic [2:0]       w_res;
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_msb = WIDTH'(is_signed) << (WIDTH - 1);
    always_comb begin
        w_sa        = r_a[r_idx*SLICE +: SLICE];
        w_sb        = r_b[r_idx*SLICE +: SLICE];
        w_fin       = r_state == COMPARE && (w_sa != w_sb || r_idx == '0);
        w_res       = w_sa != w_sb ? {1'b0, w_sa > w_sb, w_sa < w_sb} :
                      r_ce ? 3'b100 : r_cg ? 3'b010 : r_cl ? 3'b001 : 3'b100;
        w_state_nxt = r_state == IDLE ? (start ? COMPARE : IDLE) : (w_fin ? IDLE : COMPARE);
        ready       = r_state == IDLE;
        busy        = r_state == COMPARE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_ce    <= 1'b0;
            r_cg    <= 1'b0;
            r_cl    <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_fin;
            if (r_state == IDLE && start) begin
                r_a   <= A ^ w_msb;
                r_b   <= B ^ w_msb;
                r_idx <= IW'(NSLICE - 1);
                r_ce  <= isEqual;
                r_cg  <= isGreater;
                r_cl  <= isLess;
            end else if (r_state == COMPARE && !w_fin) begin
                r_idx <= r_idx - IW'(1);
            end
            if (w_fin) {r_eq, r_gt, r_lt} <= w_res;
        end
    end
    assign done      = r_done;
    assign equal     = r_eq;
    assign A_greater = r_gt;
    assign A_less    = r_lt;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: directed test-plan steps plus random operations against an arithmetic reference model.
module tb_seq_magnitude_comparator;
    localparam int WIDTH = 16;
    localparam int SLICE = 2;
    localparam int NSLICE = WIDTH / SLICE;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0;
    logic [WIDTH-1:0] A = '0, B = '0;
    logic isEqual = 1'b0, isGreater = 1'b0, isLess = 1'b0;
    logic ready, busy, done, equal, A_greater, A_less;
    int checks = 0, failures = 0;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .A(A), .B(B), .isEqual(isEqual), .isGreater(isGreater), .isLess(isLess),
        .ready(ready), .busy(busy), .done(done),
        .equal(equal), .A_greater(A_greater), .A_less(A_less)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result from plain integer ordering, latency from the highest differing bit.
    function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, b, input logic sg, e, g, l);
        if (a == b) return e ? 3'b100 : g ? 3'b010 : l ? 3'b001 : 3'b100;
        if (sg) return ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
        return (a > b) ? 3'b010 : 3'b001;
    endfunction

    function automatic int model_lat(input logic [WIDTH-1:0] a, b);
        logic [WIDTH-1:0] x;
        x = a ^ b;
        for (int p = WIDTH - 1; p >= 0; p--) if (x[p]) return NSLICE - p / SLICE;
        return NSLICE;
    endfunction

    task automatic launch(input logic [WIDTH-1:0] a, b, input logic sg, e, g, l);
        A = a; B = b; is_signed = sg; isEqual = e; isGreater = g; isLess = l; start = 1'b1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= NSLICE + 2 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (done) lat = c;
        end
    endtask

    task automatic do_op(input string tag, input logic [WIDTH-1:0] a, b, input logic sg, e, g, l,
                         input int exp_lat, input logic [2:0] exp_res);
        int lat;
        @(negedge clk);
        launch(a, b, sg, e, g, l);
        @(posedge clk); #1;
        start = 1'b0;
        A = ~a; B = ~b; is_signed = ~sg; isEqual = ~e; isGreater = ~g; isLess = ~l;
        chk({tag, "_busy"}, {30'd0, ready, busy}, 32'b01);
        wait_done(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, {equal, A_greater, A_less}, exp_res);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {30'd0, done, ready}, 32'b01);
    endtask

    initial begin
        int lat;
        logic [WIDTH-1:0] ra, rb;
        logic rs, re, rg, rl;
        #12;
        chk("reset_out", {26'd0, ready, busy, done, equal, A_greater, A_less}, 32'b100000);
        @(negedge clk); rst_n = 1'b1;

        do_op("u_8000_7fff", 16'h8000, 16'h7FFF, 0, 0, 0, 0, 1, 3'b010);
        do_op("s_8000_7fff", 16'h8000, 16'h7FFF, 1, 0, 0, 0, 1, 3'b001);
        do_op("eq_cg", 16'h1234, 16'h1234, 0, 0, 1, 0, 8, 3'b010);
        do_op("eq_ce_cg", 16'h1234, 16'h1234, 0, 1, 1, 0, 8, 3'b100);
        do_op("eq_none", 16'h1234, 16'h1234, 0, 0, 0, 0, 8, 3'b100);
        do_op("eq_cl", 16'h1234, 16'h1234, 1, 0, 0, 1, 8, 3'b001);
        do_op("u_1235_1234", 16'h1235, 16'h1234, 0, 0, 0, 1, 8, 3'b010);
        do_op("s_ffff_fffe", 16'hFFFF, 16'hFFFE, 1, 0, 0, 1, 8, 3'b010);
        do_op("u_mid_slice", 16'h0400, 16'h0800, 0, 1, 0, 0, 3, 3'b001);

        // start held during busy must be ignored
        @(negedge clk);
        launch(16'h0001, 16'h0002, 0, 0, 0, 0);
        @(posedge clk); #1;
        A = 16'hFFFF;
        lat = 0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (done) lat++;
        end
        start = 1'b0;
        chk("busy_nodone", lat, 0);
        @(posedge clk); #1;
        chk("busy_done", {29'd0, done, A_greater, A_less}, 32'b101);
        @(posedge clk); #1;
        chk("busy_single", {31'd0, done}, 32'd0);

        // start in the done cycle is accepted
        @(negedge clk);
        launch(16'h8000, 16'h7FFF, 0, 0, 0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_first", {29'd0, done, A_greater, ready}, 32'b111);
        launch(16'h0005, 16'h0005, 0, 0, 0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accept", {30'd0, busy, A_greater}, 32'b11);
        wait_done(lat);
        chk("b2b_lat", lat, 8);
        chk("b2b_res", {equal, A_greater, A_less}, 3'b001);

        // reset in the middle of an operation
        @(negedge clk);
        launch(16'h00FF, 16'h00FF, 0, 0, 1, 0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid", {26'd0, ready, busy, done, equal, A_greater, A_less}, 32'b100000);
        @(negedge clk); rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done) lat++;
        end
        chk("rst_nodone", lat, 0);

        for (int n = 0; n < 60; n++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0: rb = WIDTH'($urandom);
                1: rb = ra;
                default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            endcase
            rs = 1'($urandom); re = 1'($urandom); rg = 1'($urandom); rl = 1'($urandom);
            do_op($sformatf("rnd%0d", n), ra, rb, rs, re, rg, rl, model_lat(ra, rb), model_res(ra, rb, rs, re, rg, rl));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
